// File: rtl/strand_select_stage_pkg.sv
// Shared types and constants for the strand-select stage.
// Holds the per-strand run-state encoding, lane/holdoff widths and the
// NOP encoding driven on the instruction bus while no strand is issuing.
package strand_select_stage_pkg;

    localparam int STRANDS_PER_CORE   = 4;
    localparam int STRAND_INDEX_WIDTH = $clog2(STRANDS_PER_CORE);

    localparam int LANES         = 16;
    localparam int LANE_WIDTH    = 4;
    localparam int MC_HOLDOFF    = 3;
    localparam int HOLDOFF_WIDTH = 2;

    localparam logic [LANE_WIDTH-1:0] LAST_LANE       = LANE_WIDTH'(LANES - 1);
    localparam logic [31:0]           NOP_INSTRUCTION = 32'h0000_0000;

    typedef enum logic [1:0] {
        STRAND_DISABLED,
        STRAND_RUN,
        STRAND_SUSPENDED
    } strand_state_t;

endpackage

// File: rtl/strand_select_stage_if.sv
// Fetch/rollback-facing bundle of the strand-select stage.
//   master : fetch, rollback controller and control registers (drive the
//            per-strand request vectors, receive the issued instruction)
//   slave  : the strand-select stage itself
// ss_instruction_req is combinational; all other ss_* are registered.
interface strand_select_stage_if;
    import strand_select_stage_pkg::*;

    logic [STRANDS_PER_CORE-1:0]                 strand_enable;
    logic [STRANDS_PER_CORE-1:0]                 if_instruction_valid;
    logic [STRANDS_PER_CORE-1:0][31:0]           if_instruction;
    logic [STRANDS_PER_CORE-1:0][31:0]           if_pc;
    logic [STRANDS_PER_CORE-1:0]                 if_multi_cycle;
    logic [STRANDS_PER_CORE-1:0]                 if_multi_lane;
    logic [STRANDS_PER_CORE-1:0]                 rb_rollback_strand;
    logic [STRANDS_PER_CORE-1:0][LANE_WIDTH-1:0] rb_rollback_reg_lane;
    logic [STRANDS_PER_CORE-1:0]                 rb_suspend_strand;
    logic [STRANDS_PER_CORE-1:0]                 rb_retry_strand;
    logic [STRANDS_PER_CORE-1:0]                 resume_strand;

    logic [STRANDS_PER_CORE-1:0]                 ss_instruction_req;
    logic                                        ss_valid;
    logic [STRAND_INDEX_WIDTH-1:0]               ss_strand;
    logic [31:0]                                 ss_instruction;
    logic [31:0]                                 ss_pc;
    logic [LANE_WIDTH-1:0]                       ss_reg_lane_select;

    modport master (
        output strand_enable, if_instruction_valid, if_instruction, if_pc,
               if_multi_cycle, if_multi_lane, rb_rollback_strand,
               rb_rollback_reg_lane, rb_suspend_strand, rb_retry_strand,
               resume_strand,
        input  ss_instruction_req, ss_valid, ss_strand, ss_instruction,
               ss_pc, ss_reg_lane_select
    );

    modport slave (
        input  strand_enable, if_instruction_valid, if_instruction, if_pc,
               if_multi_cycle, if_multi_lane, rb_rollback_strand,
               rb_rollback_reg_lane, rb_suspend_strand, rb_retry_strand,
               resume_strand,
        output ss_instruction_req, ss_valid, ss_strand, ss_instruction,
               ss_pc, ss_reg_lane_select
    );

endinterface

// File: rtl/strand_select_stage_strand_fsm.sv
// Per-strand bookkeeping: run state, vector lane counter and multi-cycle
// holdoff. Reports whether the strand may be granted this cycle and whether
// a grant pops its instruction out of fetch.
// Ports:
//   clk, reset_n          clock, async active-low reset
//   strand_enable_i       control-register enable
//   instruction_valid_i   fetch holds an instruction for this strand
//   multi_cycle_i         predecode: multi-cycle instruction
//   multi_lane_i          predecode: issue once per vector lane
//   rollback_i            rollback this cycle
//   rollback_lane_i       lane to restart from after rollback
//   suspend_i, retry_i    rollback qualifiers
//   resume_i              wake-up from the memory system
//   grant_i               arbiter picked this strand
//   eligible_o            strand may be granted this cycle
//   pop_o                 grant consumes the fetched instruction
//   lane_o                lane to issue with (0 for non-multi-lane)
module strand_fsm
    import strand_select_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  strand_enable_i,
    input  logic                  instruction_valid_i,
    input  logic                  multi_cycle_i,
    input  logic                  multi_lane_i,
    input  logic                  rollback_i,
    input  logic [LANE_WIDTH-1:0] rollback_lane_i,
    input  logic                  suspend_i,
    input  logic                  retry_i,
    input  logic                  resume_i,
    input  logic                  grant_i,
    output logic                  eligible_o,
    output logic                  pop_o,
    output logic [LANE_WIDTH-1:0] lane_o
);

    strand_state_t              state_q, state_d;
    logic [LANE_WIDTH-1:0]      lane_q, lane_d;
    logic [HOLDOFF_WIDTH-1:0]   holdoff_q, holdoff_d;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= STRAND_DISABLED;
            lane_q    <= '0;
            holdoff_q <= '0;
        end else begin
            state_q   <= state_d;
            lane_q    <= lane_d;
            holdoff_q <= holdoff_d;
        end
    end

    // NOTE: every next-state value gets a default first so no path through
    // the block leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        if (!strand_enable_i) begin
            state_d = STRAND_DISABLED;
        end else begin
            unique case (state_q)
                STRAND_DISABLED:  state_d = STRAND_RUN;
                STRAND_RUN:       if (rollback_i && suspend_i && !retry_i && !resume_i)
                                      state_d = STRAND_SUSPENDED;
                STRAND_SUSPENDED: if (resume_i) state_d = STRAND_RUN;
                default:          state_d = STRAND_DISABLED;
            endcase
        end
    end

    always_comb begin
        lane_d = lane_q;
        if (rollback_i)
            lane_d = rollback_lane_i;
        else if (grant_i && multi_lane_i)
            lane_d = (lane_q == LAST_LANE) ? '0 : lane_q + 1'b1;
    end

    // Holdoff keeps counting through rollbacks; only a new multi-cycle
    // grant reloads it.
    always_comb begin
        holdoff_d = holdoff_q;
        if (grant_i && multi_cycle_i)
            holdoff_d = HOLDOFF_WIDTH'(MC_HOLDOFF);
        else if (holdoff_q != '0)
            holdoff_d = holdoff_q - 1'b1;
    end

    // A rollback in the same cycle masks the strand, so it can never be
    // granted while its lane is being rewound.
    assign eligible_o = (state_q == STRAND_RUN) && instruction_valid_i &&
                        (holdoff_q == '0) && !rollback_i;

    // Multi-lane instructions stay in fetch until their final lane issues.
    assign pop_o  = grant_i && (!multi_lane_i || (lane_q == LAST_LANE));
    assign lane_o = multi_lane_i ? lane_q : '0;

endmodule

// File: rtl/strand_select_stage.sv
// Strand-select stage: round-robin picks one eligible strand per cycle and
// registers its fetched instruction toward decode.
// Ports:
//   clk      core clock
//   reset_n  asynchronous reset, active low
//   bus      strand_select_stage_if.slave (fetch/rollback inputs, ss_* outputs)
module strand_select_stage
    import strand_select_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    strand_select_stage_if.slave  bus
);

    logic [STRANDS_PER_CORE-1:0]                 eligible;
    logic [STRANDS_PER_CORE-1:0]                 pop;
    logic [STRANDS_PER_CORE-1:0]                 grant;
    logic [STRANDS_PER_CORE-1:0][LANE_WIDTH-1:0] lane;

    for (genvar s = 0; s < STRANDS_PER_CORE; s++) begin : g_strand
        strand_fsm u_strand_fsm (
            .clk                 (clk),
            .reset_n             (reset_n),
            .strand_enable_i     (bus.strand_enable[s]),
            .instruction_valid_i (bus.if_instruction_valid[s]),
            .multi_cycle_i       (bus.if_multi_cycle[s]),
            .multi_lane_i        (bus.if_multi_lane[s]),
            .rollback_i          (bus.rb_rollback_strand[s]),
            .rollback_lane_i     (bus.rb_rollback_reg_lane[s]),
            .suspend_i           (bus.rb_suspend_strand[s]),
            .retry_i             (bus.rb_retry_strand[s]),
            .resume_i            (bus.resume_strand[s]),
            .grant_i             (grant[s]),
            .eligible_o          (eligible[s]),
            .pop_o               (pop[s]),
            .lane_o              (lane[s])
        );
    end

    logic [STRAND_INDEX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [STRAND_INDEX_WIDTH-1:0] grant_idx, candidate;
    logic                          grant_any;

    // Search starts one past the last grant; the index wraps naturally
    // because the strand count is a power of two.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        candidate = '0;
        for (int i = 1; i <= STRANDS_PER_CORE; i++) begin
            candidate = rr_ptr_q + STRAND_INDEX_WIDTH'(i);
            if (!grant_any && eligible[candidate]) begin
                grant_any = 1'b1;
                grant_idx = candidate;
            end
        end
        grant            = '0;
        grant[grant_idx] = grant_any;
        rr_ptr_d         = grant_any ? grant_idx : rr_ptr_q;
    end

    logic                          ss_valid_q, ss_valid_d;
    logic [STRAND_INDEX_WIDTH-1:0] ss_strand_q, ss_strand_d;
    logic [31:0]                   ss_instruction_q, ss_instruction_d;
    logic [31:0]                   ss_pc_q, ss_pc_d;
    logic [LANE_WIDTH-1:0]         ss_lane_q, ss_lane_d;

    // Idle cycles present a clean NOP with every field zeroed.
    always_comb begin
        ss_valid_d       = grant_any;
        ss_strand_d      = '0;
        ss_instruction_d = NOP_INSTRUCTION;
        ss_pc_d          = '0;
        ss_lane_d        = '0;
        if (grant_any) begin
            ss_strand_d      = grant_idx;
            ss_instruction_d = bus.if_instruction[grant_idx];
            ss_pc_d          = bus.if_pc[grant_idx];
            ss_lane_d        = lane[grant_idx];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q         <= '0;
            ss_valid_q       <= 1'b0;
            ss_strand_q      <= '0;
            ss_instruction_q <= NOP_INSTRUCTION;
            ss_pc_q          <= '0;
            ss_lane_q        <= '0;
        end else begin
            rr_ptr_q         <= rr_ptr_d;
            ss_valid_q       <= ss_valid_d;
            ss_strand_q      <= ss_strand_d;
            ss_instruction_q <= ss_instruction_d;
            ss_pc_q          <= ss_pc_d;
            ss_lane_q        <= ss_lane_d;
        end
    end

    assign bus.ss_instruction_req = pop;
    assign bus.ss_valid           = ss_valid_q;
    assign bus.ss_strand          = ss_strand_q;
    assign bus.ss_instruction     = ss_instruction_q;
    assign bus.ss_pc              = ss_pc_q;
    assign bus.ss_reg_lane_select = ss_lane_q;

endmodule

// File: tb/tb_strand_select_stage.sv
// Directed bench for strand_select_stage. Inputs change 1 ns after a rising
// edge and define that cycle; registered outputs observed after the next
// edge therefore reflect the grant made in the previous cycle.
module tb_strand_select_stage;
    import strand_select_stage_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    strand_select_stage_if bus_if ();

    strand_select_stage dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if.slave)
    );

    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] instr_of(int s);
        return 32'hC0DE_0000 + 32'(s) * 32'h11;
    endfunction

    function automatic logic [31:0] pc_of(int s);
        return 32'h0000_1000 + 32'(s) * 32'h4;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus_if.if_instruction_valid = '0;
        bus_if.if_multi_cycle       = '0;
        bus_if.if_multi_lane        = '0;
        bus_if.rb_rollback_strand   = '0;
        bus_if.rb_rollback_reg_lane = '0;
        bus_if.rb_suspend_strand    = '0;
        bus_if.rb_retry_strand      = '0;
        bus_if.resume_strand        = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus_if.strand_enable = '0;
        clear_inputs();
        for (int s = 0; s < STRANDS_PER_CORE; s++) begin
            bus_if.if_instruction[s] = instr_of(s);
            bus_if.if_pc[s]          = pc_of(s);
        end
        #3;
        checks++; if (bus_if.ss_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus_if.ss_valid); end
        checks++; if (bus_if.ss_strand !== '0) begin errors++; $display("FAIL reset_strand: got %0d want 0", bus_if.ss_strand); end
        checks++; if (bus_if.ss_instruction !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", bus_if.ss_instruction); end
        checks++; if (bus_if.ss_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", bus_if.ss_pc); end
        checks++; if (bus_if.ss_reg_lane_select !== 4'h0) begin errors++; $display("FAIL reset_lane: got %0d want 0", bus_if.ss_reg_lane_select); end
        checks++; if (bus_if.ss_instruction_req !== 4'b0000) begin errors++; $display("FAIL reset_req: got %b want 0000", bus_if.ss_instruction_req); end
        #5 reset_n = 1'b1;
    endtask

    // Strand 0 gets a one-cycle head start so the pointer (reset to 0) then
    // rotates 1,2,3,0 with all four valid.
    task automatic test_round_robin();
        int exp_strand [4] = '{1, 2, 3, 0};
        bus_if.strand_enable        = 4'b1111;
        bus_if.if_instruction_valid = 4'b0001;
        tick();  // strands leave DISABLED at this edge
        checks++; if (bus_if.ss_instruction_req !== 4'b0001) begin errors++; $display("FAIL rr_first_req: got %b want 0001", bus_if.ss_instruction_req); end
        tick();
        bus_if.if_instruction_valid = 4'b1111;
        checks++; if (bus_if.ss_valid !== 1'b1 || bus_if.ss_strand !== 2'd0) begin errors++; $display("FAIL rr_issue0: got v=%b s=%0d want v=1 s=0", bus_if.ss_valid, bus_if.ss_strand); end
        checks++; if (bus_if.ss_instruction !== instr_of(0) || bus_if.ss_pc !== pc_of(0)) begin errors++; $display("FAIL rr_payload0: got %h/%h want %h/%h", bus_if.ss_instruction, bus_if.ss_pc, instr_of(0), pc_of(0)); end
        #1;
        checks++; if (bus_if.ss_instruction_req !== 4'b0010) begin errors++; $display("FAIL rr_all_req: got %b want 0010", bus_if.ss_instruction_req); end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (bus_if.ss_valid !== 1'b1 || bus_if.ss_strand !== 2'(exp_strand[k])) begin errors++; $display("FAIL rr_grant[%0d]: got v=%b s=%0d want v=1 s=%0d", k, bus_if.ss_valid, bus_if.ss_strand, exp_strand[k]); end
            checks++; if (bus_if.ss_instruction !== instr_of(exp_strand[k]) || bus_if.ss_reg_lane_select !== 4'h0) begin errors++; $display("FAIL rr_payload[%0d]: got %h lane %0d want %h lane 0", k, bus_if.ss_instruction, bus_if.ss_reg_lane_select, instr_of(exp_strand[k])); end
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_multi_lane();
        bus_if.if_instruction_valid = 4'b0010;
        bus_if.if_multi_lane        = 4'b0010;
        for (int i = 0; i < LANES; i++) begin
            #1;
            checks++; if (bus_if.ss_instruction_req !== ((i == LANES - 1) ? 4'b0010 : 4'b0000)) begin errors++; $display("FAIL ml_req[%0d]: got %b want %b", i, bus_if.ss_instruction_req, (i == LANES - 1) ? 4'b0010 : 4'b0000); end
            tick();
            checks++; if (bus_if.ss_valid !== 1'b1 || bus_if.ss_strand !== 2'd1 || bus_if.ss_reg_lane_select !== 4'(i)) begin errors++; $display("FAIL ml_issue[%0d]: got v=%b s=%0d lane=%0d want v=1 s=1 lane=%0d", i, bus_if.ss_valid, bus_if.ss_strand, bus_if.ss_reg_lane_select, i); end
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_lane_rollback();
        bus_if.if_instruction_valid = 4'b0100;
        bus_if.if_multi_lane        = 4'b0100;
        for (int i = 0; i < 7; i++) tick();
        checks++; if (bus_if.ss_reg_lane_select !== 4'd6) begin errors++; $display("FAIL rb_pre_lane: got %0d want 6", bus_if.ss_reg_lane_select); end
        bus_if.rb_rollback_strand      = 4'b0100;
        bus_if.rb_rollback_reg_lane[2] = 4'd5;
        #1;
        checks++; if (bus_if.ss_instruction_req !== 4'b0000) begin errors++; $display("FAIL rb_req: got %b want 0000", bus_if.ss_instruction_req); end
        tick();
        bus_if.rb_rollback_strand = '0;
        checks++; if (bus_if.ss_valid !== 1'b0) begin errors++; $display("FAIL rb_no_issue: got %b want 0", bus_if.ss_valid); end
        #1;
        checks++; if (bus_if.ss_instruction_req !== 4'b0000) begin errors++; $display("FAIL rb_resume_req: got %b want 0000", bus_if.ss_instruction_req); end
        tick();
        checks++; if (bus_if.ss_valid !== 1'b1 || bus_if.ss_strand !== 2'd2 || bus_if.ss_reg_lane_select !== 4'd5) begin errors++; $display("FAIL rb_lane5: got v=%b s=%0d lane=%0d want v=1 s=2 lane=5", bus_if.ss_valid, bus_if.ss_strand, bus_if.ss_reg_lane_select); end
        tick();
        checks++; if (bus_if.ss_reg_lane_select !== 4'd6) begin errors++; $display("FAIL rb_lane6: got %0d want 6", bus_if.ss_reg_lane_select); end
        clear_inputs();
        tick();
    endtask

    task automatic test_suspend_resume();
        bus_if.if_instruction_valid = 4'b1000;
        bus_if.rb_rollback_strand   = 4'b1000;
        bus_if.rb_suspend_strand    = 4'b1000;
        #1;
        checks++; if (bus_if.ss_instruction_req !== 4'b0000) begin errors++; $display("FAIL susp_rb_req: got %b want 0000", bus_if.ss_instruction_req); end
        tick();
        bus_if.rb_rollback_strand = '0;
        bus_if.rb_suspend_strand  = '0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (bus_if.ss_valid !== 1'b0) begin errors++; $display("FAIL susp_idle[%0d]: got %b want 0", k, bus_if.ss_valid); end
            #1;
            checks++; if (bus_if.ss_instruction_req !== 4'b0000) begin errors++; $display("FAIL susp_req[%0d]: got %b want 0000", k, bus_if.ss_instruction_req); end
            tick();
        end
        bus_if.resume_strand = 4'b1000;
        #1;
        checks++; if (bus_if.ss_instruction_req !== 4'b0000) begin errors++; $display("FAIL resume_cycle_req: got %b want 0000", bus_if.ss_instruction_req); end
        tick();
        bus_if.resume_strand = '0;
        #1;
        checks++; if (bus_if.ss_instruction_req !== 4'b1000) begin errors++; $display("FAIL resume_req: got %b want 1000", bus_if.ss_instruction_req); end
        tick();
        checks++; if (bus_if.ss_valid !== 1'b1 || bus_if.ss_strand !== 2'd3) begin errors++; $display("FAIL resume_issue: got v=%b s=%0d want v=1 s=3", bus_if.ss_valid, bus_if.ss_strand); end
        clear_inputs();
        tick();
    endtask

    // Variant 0: suspend with coincident resume; variant 1: suspend with retry.
    task automatic test_suspend_cancel();
        bus_if.if_instruction_valid = 4'b0001;
        for (int v = 0; v < 2; v++) begin
            bus_if.rb_rollback_strand = 4'b0001;
            bus_if.rb_suspend_strand  = 4'b0001;
            bus_if.resume_strand      = (v == 0) ? 4'b0001 : 4'b0000;
            bus_if.rb_retry_strand    = (v == 1) ? 4'b0001 : 4'b0000;
            #1;
            checks++; if (bus_if.ss_instruction_req !== 4'b0000) begin errors++; $display("FAIL cancel_rb_req[%0d]: got %b want 0000", v, bus_if.ss_instruction_req); end
            tick();
            bus_if.rb_rollback_strand = '0;
            bus_if.rb_suspend_strand  = '0;
            bus_if.resume_strand      = '0;
            bus_if.rb_retry_strand    = '0;
            #1;
            checks++; if (bus_if.ss_instruction_req !== 4'b0001) begin errors++; $display("FAIL cancel_req[%0d]: got %b want 0001", v, bus_if.ss_instruction_req); end
            tick();
            checks++; if (bus_if.ss_valid !== 1'b1 || bus_if.ss_strand !== 2'd0) begin errors++; $display("FAIL cancel_issue[%0d]: got v=%b s=%0d want v=1 s=0", v, bus_if.ss_valid, bus_if.ss_strand); end
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_multi_cycle_and_reset();
        bus_if.if_instruction_valid = 4'b0001;
        bus_if.if_multi_cycle       = 4'b0001;
        #1;
        checks++; if (bus_if.ss_instruction_req !== 4'b0001) begin errors++; $display("FAIL mc_first_req: got %b want 0001", bus_if.ss_instruction_req); end
        tick();
        checks++; if (bus_if.ss_valid !== 1'b1 || bus_if.ss_strand !== 2'd0) begin errors++; $display("FAIL mc_issue: got v=%b s=%0d want v=1 s=0", bus_if.ss_valid, bus_if.ss_strand); end
        for (int k = 0; k < MC_HOLDOFF; k++) begin
            tick();
            checks++; if (bus_if.ss_valid !== 1'b0 || bus_if.ss_instruction !== NOP_INSTRUCTION) begin errors++; $display("FAIL mc_idle[%0d]: got v=%b instr=%h want v=0 instr=0", k, bus_if.ss_valid, bus_if.ss_instruction); end
            checks++; if (bus_if.ss_instruction_req !== ((k == MC_HOLDOFF - 1) ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL mc_req[%0d]: got %b want %b", k, bus_if.ss_instruction_req, (k == MC_HOLDOFF - 1) ? 4'b0001 : 4'b0000); end
        end
        tick();
        checks++; if (bus_if.ss_valid !== 1'b1 || bus_if.ss_strand !== 2'd0 || bus_if.ss_instruction !== instr_of(0)) begin errors++; $display("FAIL mc_reissue: got v=%b s=%0d instr=%h want v=1 s=0 instr=%h", bus_if.ss_valid, bus_if.ss_strand, bus_if.ss_instruction, instr_of(0)); end
        // Reset mid-cycle, away from any clock edge.
        #2 reset_n = 1'b0;
        #1;
        checks++; if (bus_if.ss_valid !== 1'b0 || bus_if.ss_instruction !== 32'h0 || bus_if.ss_pc !== 32'h0) begin errors++; $display("FAIL async_reset_out: got v=%b instr=%h pc=%h want all 0", bus_if.ss_valid, bus_if.ss_instruction, bus_if.ss_pc); end
        checks++; if (bus_if.ss_instruction_req !== 4'b0000) begin errors++; $display("FAIL async_reset_req: got %b want 0000", bus_if.ss_instruction_req); end
        bus_if.if_multi_cycle = '0;
        tick();
        #2 reset_n = 1'b1;
        #1;
        checks++; if (bus_if.ss_instruction_req !== 4'b0000) begin errors++; $display("FAIL post_reset_disabled: got %b want 0000", bus_if.ss_instruction_req); end
        tick();
        checks++; if (bus_if.ss_instruction_req !== 4'b0001) begin errors++; $display("FAIL post_reset_run: got %b want 0001", bus_if.ss_instruction_req); end
        tick();
        checks++; if (bus_if.ss_valid !== 1'b1 || bus_if.ss_strand !== 2'd0) begin errors++; $display("FAIL post_reset_issue: got v=%b s=%0d want v=1 s=0", bus_if.ss_valid, bus_if.ss_strand); end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        tick();
        test_round_robin();
        test_multi_lane();
        test_lane_rollback();
        test_suspend_resume();
        test_suspend_cancel();
        test_multi_cycle_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
